// File: rtl/acc_mac_unit.sv
// Shift-and-add unsigned MAC/MUL accelerator: WIDTH RUN cycles, accdone in the cycle after RUN.
// No backpressure: a request is taken only in IDLE, and accbypass is ignored while RUN/DONE.
module acc_mac_unit #(
  parameter int WIDTH = 32,
  parameter int ACC_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             accbypass,
  input  logic [5:0]       opD,
  input  logic [WIDTH-1:0] srcaD,
  input  logic [WIDTH-1:0] srcbD,
  output logic             accdone,
  output logic             busy,
  output logic [ACC_W-1:0] acc_out
);

  localparam logic [5:0] OP_MAC = 6'b111111;
  localparam logic [5:0] OP_MUL = 6'b111110;
  localparam int         CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [ACC_W-1:0]   mcand;
  logic [ACC_W-1:0]   prod;
  logic [ACC_W-1:0]   prod_next;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               mode;
  logic               start;
  logic               last;

  assign start     = (state == IDLE) && accbypass && ((opD == OP_MAC) || (opD == OP_MUL));
  assign last      = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
  assign prod_next = mplier[0] ? (prod + mcand) : prod;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // acc_out is only written on the final RUN edge, so an aborted op never leaks a partial product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      prod    <= '0;
      cnt     <= '0;
      mode    <= 1'b0;
      acc_out <= '0;
    end else if (start) begin
      mcand  <= ACC_W'(srcaD);
      mplier <= srcbD;
      mode   <= opD[0];
      prod   <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      prod   <= prod_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (last) begin
        acc_out <= mode ? (acc_out + prod_next) : prod_next;
      end
    end
  end

  assign busy    = (state != IDLE);
  assign accdone = (state == DONE);

endmodule

// File: tb/tb_acc_mac_unit.sv
// Directed vector table plus randomized ops checked against an arithmetic accumulator model.
module tb_acc_mac_unit;

  localparam int WIDTH = 32;
  localparam int ACC_W = 64;
  localparam logic [5:0] OP_MAC = 6'b111111;
  localparam logic [5:0] OP_MUL = 6'b111110;

  logic             clk;
  logic             reset;
  logic             accbypass;
  logic [5:0]       opD;
  logic [WIDTH-1:0] srcaD;
  logic [WIDTH-1:0] srcbD;
  logic             accdone;
  logic             busy;
  logic [ACC_W-1:0] acc_out;

  int checks;
  int errors;
  logic [ACC_W-1:0] model_acc;

  acc_mac_unit #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .accbypass (accbypass),
    .opD       (opD),
    .srcaD     (srcaD),
    .srcbD     (srcbD),
    .accdone   (accdone),
    .busy      (busy),
    .acc_out   (acc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    bit               scramble;
    logic [ACC_W-1:0] exp_acc;
  } vec_t;

  task automatic chk(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [ACC_W-1:0] model_step(input logic [5:0] op, input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b, input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] p;
    p = ACC_W'(a) * ACC_W'(b);
    return (op == OP_MAC) ? acc + p : p;
  endfunction

  // Starts at a negedge in IDLE; returns at the negedge of the DONE cycle with accbypass dropped.
  task automatic do_op(input logic [5:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input bit scramble, output int lat);
    bit saw_early;
    @(negedge clk);
    chk("idle_before_op", {62'd0, busy, accdone}, 64'd0);
    accbypass = 1'b1;
    opD       = op;
    srcaD     = a;
    srcbD     = b;
    lat       = 0;
    saw_early = 1'b0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk("busy_in_run", {63'd0, busy}, 64'd1);
      if (scramble) begin
        srcaD = $urandom;
        srcbD = $urandom;
        opD   = 6'($urandom);
      end
      if (accdone) break;
      if (lat > WIDTH + 10) begin
        saw_early = 1'b1;
        break;
      end
    end
    if (saw_early) chk("accdone_timeout", 64'd0, 64'd1);
    accbypass = 1'b0;
    opD       = 6'd0;
  endtask

  vec_t vecs[6];
  int   lat;
  bit   bad;
  logic [5:0] rop;
  logic [WIDTH-1:0] ra, rb;

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    accbypass = 1'b0;
    opD       = 6'd0;
    srcaD     = '0;
    srcbD     = '0;
    model_acc = '0;

    vecs[0] = '{OP_MUL, 32'd3, 32'd5, 1'b0, 64'd15};
    vecs[1] = '{OP_MAC, 32'd7, 32'd6, 1'b0, 64'd57};
    vecs[2] = '{OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
    vecs[3] = '{OP_MAC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFC_0000_0002};
    vecs[4] = '{OP_MUL, 32'h1234, 32'h5678, 1'b1, 64'h1234 * 64'h5678};
    vecs[5] = '{OP_MAC, 32'h8000_0001, 32'd2, 1'b1, 64'h1234 * 64'h5678 + 64'h1_0000_0002};

    repeat (2) @(negedge clk);
    chk("reset_acc_out", acc_out, 64'd0);
    chk("reset_flags", {62'd0, busy, accdone}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].scramble, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(WIDTH + 1));
      chk($sformatf("vec%0d_acc", i), acc_out, vecs[i].exp_acc);
      model_acc = model_step(vecs[i].op, vecs[i].a, vecs[i].b, model_acc);
    end
    chk("table_vs_model", acc_out, model_acc);

    // Unrecognised opcode with accbypass high must be ignored entirely.
    @(negedge clk);
    chk("pulse_one_cycle", {62'd0, busy, accdone}, 64'd0);
    accbypass = 1'b1;
    opD       = 6'b000000;
    srcaD     = 32'd9;
    srcbD     = 32'd9;
    bad       = 1'b0;
    repeat (WIDTH + 4) begin
      @(negedge clk);
      if (busy || accdone) bad = 1'b1;
    end
    chk("bad_opcode_ignored", {63'd0, bad}, 64'd0);
    chk("bad_opcode_acc_kept", acc_out, model_acc);
    accbypass = 1'b0;

    // Abort at RUN cycle 10 with an async reset.
    @(negedge clk);
    accbypass = 1'b1;
    opD       = OP_MAC;
    srcaD     = 32'd1000;
    srcbD     = 32'd1000;
    repeat (10) @(negedge clk);
    chk("busy_before_abort", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    chk("abort_acc_zero", acc_out, 64'd0);
    chk("abort_flags_zero", {62'd0, busy, accdone}, 64'd0);
    accbypass = 1'b0;
    @(negedge clk);
    reset     = 1'b0;
    model_acc = '0;
    do_op(OP_MUL, 32'd2, 32'd2, 1'b0, lat);
    chk("after_abort_latency", 64'(lat), 64'(WIDTH + 1));
    chk("after_abort_acc", acc_out, 64'd4);
    model_acc = 64'd4;

    // Random back-to-back ops against the model.
    for (int i = 0; i < 24; i++) begin
      rop = ($urandom_range(0, 1) == 1) ? OP_MAC : OP_MUL;
      ra  = $urandom;
      rb  = (i % 5 == 0) ? 32'hFFFF_FFFF : $urandom;
      do_op(rop, ra, rb, (i % 3 == 0), lat);
      model_acc = model_step(rop, ra, rb, model_acc);
      chk($sformatf("rand%0d_latency", i), 64'(lat), 64'(WIDTH + 1));
      chk($sformatf("rand%0d_acc", i), acc_out, model_acc);
    end

    @(negedge clk);
    chk("final_idle", {62'd0, busy, accdone}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
